uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the FIFO entry count; legal values are powers of two from 2 to 256.
REQ-002 SHALL have parameter DW, default 8, meaning the byte width fed to the transmitter.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port wr_valid_i, input, 1 bit: byte offered by the bus slave, e.g. a write to address 0.
REQ-006 SHALL have port wr_data_i, input, DW bits: the offered byte.
REQ-007 SHALL have port wr_ready_o, output, 1 bit: FIFO not full.
REQ-008 SHALL have port tx_data_o, output, DW bits: byte to the transmitter's d input.
REQ-009 SHALL have port tx_ena_o, output, 1 bit: one-cycle launch pulse to the transmitter's ena input.
REQ-010 SHALL have port tx_ready_i, input, 1 bit: transmitter idle, from the transmitter's ready output.
REQ-011 SHALL have port count_o, output, $clog2(DEPTH)+1 bits: current fill level.
REQ-012 SHALL have port empty_o, output, 1 bit: count_o==0.
REQ-013 SHALL have port full_o, output, 1 bit: count_o==DEPTH.
REQ-014 SHALL have port ovf_clr_i, input, 1 bit: clears the overflow flag.
REQ-015 SHALL have port ovf_o, output, 1 bit: sticky overflow flag.

Function
REQ-016 SHALL accept a push only in a cycle where wr_valid_i and wr_ready_o are both high; wr_ready_o SHALL equal ~full_o, with no write-through when full.
REQ-017 SHALL silently drop a byte offered with wr_valid_i high while full; the FIFO content SHALL stay unchanged.
REQ-018 SHALL wrap the read and write pointers modulo DEPTH; count_o SHALL be held in a separate counter.
REQ-019 SHALL leave count_o unchanged when a push and a pop occur in the same cycle.
REQ-020 SHALL implement an FSM with three states:
- IDLE -> LAUNCH when count_o!=0 and tx_ready_i==1;
- LAUNCH -> GUARD unconditionally;
- GUARD -> IDLE when tx_ready_i==1, otherwise stay in GUARD.
REQ-021 SHALL pop the head entry and register it into tx_data_o on the IDLE->LAUNCH edge.
REQ-022 SHALL hold tx_data_o stable until the next pop.
REQ-023 SHALL drive tx_ena_o as a registered output, high exactly during the LAUNCH cycle.
REQ-024 SHALL ignore tx_ready_i during GUARD's first cycle, to cover the transmitter's one-cycle ready deassert latency.
REQ-025 SHALL assert tx_ena_o, for a byte pushed into an empty FIFO with tx_ready_i high, in the second cycle after the accepting edge.
REQ-026 SHALL space back-to-back launches by no less than 3 cycles.
REQ-027 SHALL produce exactly one tx_ena_o pulse per pushed byte, in push order.
REQ-028 SHALL never pop when empty.

Reset
REQ-029 SHALL, when rst_i is sampled high, set the state to IDLE, pointers and count_o to 0, tx_data_o to 0, tx_ena_o to 0 and ovf_o to 0; empty_o SHALL be 1, full_o 0 and wr_ready_o 1.
REQ-030 SHALL, on reset mid-transfer, discard all stored bytes and not issue any further tx_ena_o; the byte already launched SHALL complete in the transmitter.
REQ-031 SHALL take rst_i priority over push, pop and ovf_clr_i in the same cycle.

Configuration
REQ-032 SHALL, with macro UART_TX_FIFO_OVF_FLAG_EN defined, set ovf_o on any cycle where wr_valid_i is high and full_o is high.
REQ-033 SHALL, with UART_TX_FIFO_OVF_FLAG_EN defined, clear ovf_o on ovf_clr_i; set SHALL win when set and clear coincide.
REQ-034 SHALL, without UART_TX_FIFO_OVF_FLAG_EN, tie ovf_o to 0 and ignore ovf_clr_i; the port list SHALL be identical in both builds.

Structure
REQ-035 SHALL take the FSM state enum (IDLE, LAUNCH, GUARD) and the default DW/DEPTH constants from shared package uart_pkg.
REQ-036 SHALL place the storage array in one sub-module, uart_fifo_mem: a DEPTH x DW register array with synchronous write and combinational read by address; pointer and FSM logic SHALL stay in uart_tx_fifo.

Verification
REQ-037 SHALL cover single byte: push 0x48 while empty with tx_ready_i=1 -> tx_ena_o high in cycle +2, tx_data_o=0x48, count_o 1->0.
REQ-038 SHALL cover burst: push "Hello world!" (12 bytes) with tx_ready_i low for 12 bytes of time -> count_o=12, then 12 pulses in order 0x48..0x21, none closer than 3 cycles.
REQ-039 SHALL cover full: DEPTH=16, push 17 bytes with tx_ready_i=0 -> full_o=1 and wr_ready_o=0 after 16; the 17th byte is dropped; ovf_o=1 only in the _EN build.
REQ-040 SHALL cover simultaneous push and pop: count_o=5, a push in the LAUNCH-entry cycle -> count_o stays 5 and the order is preserved.
REQ-041 SHALL cover reset mid-operation: count_o=7 while in GUARD, rst_i high for 1 cycle -> count_o=0, IDLE, and no tx_ena_o afterwards.
REQ-042 SHALL cover pointer wrap: 40 bytes streamed with DEPTH=16 -> all 40 bytes are delivered in order.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART transmit FIFO.
// Latency: none (declarations only).
// Backpressure: not applicable.
package uart_pkg;

    // Default byte width fed to the transmitter.
    localparam int UART_DW_DEFAULT    = 8;

    // Default FIFO entry count (power of two, 2..256).
    localparam int UART_DEPTH_DEFAULT = 16;

    // Launch sequencer states.
    // IDLE   : waiting for a stored byte and an idle transmitter
    // LAUNCH : the single cycle in which tx_ena_o is high
    // GUARD  : waiting for the transmitter to report idle again
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        GUARD  = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DW storage array for the UART transmit FIFO.
// Latency: write lands on the next rising edge; read is combinational.
// Backpressure: none here; the caller only writes when a slot is free.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_DEPTH_DEFAULT,
    parameter int DW    = UART_DW_DEFAULT,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Store the offered byte in the addressed slot. Contents need no reset:
    // the pointers and count decide which slots are valid.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Head entry is presented combinationally so it can be captured on the pop edge.
    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between a bus slave and a UART transmitter, with a launch sequencer.
// Latency: byte pushed into an empty FIFO with transmitter idle -> tx_ena_o two cycles later.
// Backpressure: wr_ready_o = ~full; writes offered while full are dropped (flagged when UART_TX_FIFO_OVF_FLAG_EN is defined).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_DEPTH_DEFAULT,
    parameter int DW    = UART_DW_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_valid_i,
    input  logic [DW-1:0]            wr_data_i,
    output logic                     wr_ready_o,
    output logic [DW-1:0]            tx_data_o,
    output logic                     tx_ena_o,
    input  logic                     tx_ready_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o,
    input  logic                     ovf_clr_i,
    output logic                     ovf_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    tx_state_e     state_q, state_d;
    logic          guard_first_q, guard_first_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] tx_data_q, tx_data_d;
    logic          tx_ena_q, tx_ena_d;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [DW-1:0] head_data;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // No write-through: a push is only accepted while a slot is free.
    assign push  = wr_valid_i && !full;

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_mem (
        .clk_i     (clk_i),
        .wr_en_i   (push),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_data_i),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (head_data)
    );

    // Launch sequencer: pop and pulse tx_ena_o once per byte, then wait in GUARD
    // until the transmitter is idle. The first GUARD cycle ignores tx_ready_i because
    // the transmitter only drops ready one cycle after it sees ena.
    always_comb begin
        state_d       = state_q;
        guard_first_d = 1'b0;
        tx_ena_d      = 1'b0;
        pop           = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && tx_ready_i) begin
                    state_d  = LAUNCH;
                    tx_ena_d = 1'b1;
                    pop      = 1'b1;
                end
            end
            LAUNCH: begin
                state_d       = GUARD;
                guard_first_d = 1'b1;
            end
            GUARD: begin
                if (!guard_first_q && tx_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pointer, fill-count and output-byte next state. Pointers wrap naturally at
    // DEPTH because DEPTH is a power of two; the count is kept separately so that
    // full and empty are unambiguous.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        tx_data_d = tx_data_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + AW'(1);
            tx_data_d = head_data;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State and datapath registers; reset wins over push, pop and launch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            guard_first_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            tx_data_q     <= '0;
            tx_ena_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            guard_first_q <= guard_first_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            tx_data_q     <= tx_data_d;
            tx_ena_q      <= tx_ena_d;
        end
    end

`ifdef UART_TX_FIFO_OVF_FLAG_EN
    logic ovf_q, ovf_d;

    // Sticky overflow: any write attempt while full sets it; set beats clear.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
        if (wr_valid_i && full) begin
            ovf_d = 1'b1;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`else
    // Flag disabled: the clear input is kept on the port list but has no effect.
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr_i;
    assign ovf_o          = 1'b0;
`endif

    assign wr_ready_o = !full;
    assign tx_data_o  = tx_data_q;
    assign tx_ena_o   = tx_ena_q;
    assign count_o    = count_q;
    assign empty_o    = empty;
    assign full_o     = full;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo (DEPTH=16, DW=8).
// Latency: table rows sample one cycle after each applied input set.
// Backpressure: a small transmitter model drops ready for two cycles after each launch.
module tb_uart_tx_fifo;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       wr_valid_i;
    logic [7:0] wr_data_i;
    logic       wr_ready_o;
    logic [7:0] tx_data_o;
    logic       tx_ena_o;
    logic       tx_ready_i;
    logic [4:0] count_o;
    logic       empty_o;
    logic       full_o;
    logic       ovf_clr_i;
    logic       ovf_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb[$];
    logic       tx_hold;
    int         busy = 0;
    int         cyc = 0;
    int         last_ena = -1;

`ifdef UART_TX_FIFO_OVF_FLAG_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    uart_tx_fifo #(.DEPTH(16), .DW(8)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_valid_i (wr_valid_i),
        .wr_data_i  (wr_data_i),
        .wr_ready_o (wr_ready_o),
        .tx_data_o  (tx_data_o),
        .tx_ena_o   (tx_ena_o),
        .tx_ready_i (tx_ready_i),
        .count_o    (count_o),
        .empty_o    (empty_o),
        .full_o     (full_o),
        .ovf_clr_i  (ovf_clr_i),
        .ovf_o      (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    // Transmitter model: ready falls one cycle after ena and stays low two cycles.
    always @(posedge clk_i) begin
        if (tx_ena_o) busy <= 2;
        else if (busy != 0) busy <= busy - 1;
    end
    assign tx_ready_i = !tx_hold && (busy == 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every launch must carry the oldest outstanding byte, 3+ cycles apart.
    always @(negedge clk_i) begin
        cyc++;
        if (!rst_i && tx_ena_o) begin
            if (sb.size() == 0) begin
                check("unexpected_ena", 32'(tx_data_o), 32'hFFFF_FFFF);
            end else begin
                check("tx_data_order", 32'(tx_data_o), 32'(sb.pop_front()));
                if (last_ena >= 0) check("launch_spacing_ge3", 32'(cyc - last_ena >= 3), 32'd1);
                last_ena = cyc;
            end
        end
    end

    // Offer a byte and hold it until accepted; called and returns at posedge+1.
    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        wr_valid_i = 1'b1;
        wr_data_i  = b;
        while (!wr_ready_o && n < 200) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!wr_ready_o) begin
            check("push_timeout", 32'd0, 32'd1);
            wr_valid_i = 1'b0;
            return;
        end
        sb.push_back(b);
        @(posedge clk_i); #1;
        wr_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || count_o != 0 || busy != 0) && n < 3000) begin
            @(posedge clk_i); #1;
            n++;
        end
        repeat (8) @(posedge clk_i);
        #1;
        check(name, 32'(sb.size()), 32'd0);
    endtask

    typedef struct packed {
        logic       wr_valid;
        logic [7:0] wr_data;
        logic [4:0] exp_count;
        logic       exp_ena;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1'b1, 8'h48, 5'd1, 1'b0, 8'h00}; // accepted, nothing launched yet
        tbl[1] = '{1'b0, 8'h00, 5'd0, 1'b1, 8'h48}; // launch two cycles after accept
        tbl[2] = '{1'b0, 8'h00, 5'd0, 1'b0, 8'h48}; // GUARD, data held
        tbl[3] = '{1'b0, 8'h00, 5'd0, 1'b0, 8'h48};
        tbl[4] = '{1'b0, 8'h00, 5'd0, 1'b0, 8'h48};
        tbl[5] = '{1'b0, 8'h00, 5'd0, 1'b0, 8'h48}; // back to IDLE
        tbl[6] = '{1'b1, 8'h69, 5'd1, 1'b0, 8'h48};
        tbl[7] = '{1'b0, 8'h00, 5'd0, 1'b1, 8'h69};

        rst_i = 1'b1; wr_valid_i = 1'b0; wr_data_i = '0; ovf_clr_i = 1'b0; tx_hold = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_empty", 32'(empty_o), 32'd1);
        check("rst_full", 32'(full_o), 32'd0);
        check("rst_wr_ready", 32'(wr_ready_o), 32'd1);
        check("rst_tx_ena", 32'(tx_ena_o), 32'd0);
        check("rst_tx_data", 32'(tx_data_o), 32'd0);
        check("rst_ovf", 32'(ovf_o), 32'd0);

        // Single byte, cycle by cycle.
        for (int i = 0; i < 8; i++) begin
            wr_valid_i = tbl[i].wr_valid;
            wr_data_i  = tbl[i].wr_data;
            if (tbl[i].wr_valid) sb.push_back(tbl[i].wr_data);
            @(posedge clk_i); #1;
            wr_valid_i = 1'b0;
            check($sformatf("tbl%0d_count", i), 32'(count_o), 32'(tbl[i].exp_count));
            check($sformatf("tbl%0d_ena", i), 32'(tx_ena_o), 32'(tbl[i].exp_ena));
            check($sformatf("tbl%0d_data", i), 32'(tx_data_o), 32'(tbl[i].exp_data));
            check($sformatf("tbl%0d_empty", i), 32'(empty_o), 32'(tbl[i].exp_count == 0));
        end
        wait_drain("single_drain");

        // Burst "Hello world!" while the transmitter is held busy.
        begin
            logic [7:0] msg [12];
            msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};
            tx_hold = 1'b1;
            for (int i = 0; i < 12; i++) push_byte(msg[i]);
            check("burst_count12", 32'(count_o), 32'd12);
            tx_hold = 1'b0;
            wait_drain("burst_drain");
        end

        // Fill to DEPTH, drop the 17th, exercise the overflow flag.
        tx_hold = 1'b1;
        for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i));
        check("full_flag", 32'(full_o), 32'd1);
        check("full_wr_ready", 32'(wr_ready_o), 32'd0);
        check("full_count", 32'(count_o), 32'd16);
        wr_valid_i = 1'b1; wr_data_i = 8'hEE;
        @(posedge clk_i); #1;
        check("drop_count", 32'(count_o), 32'd16);
        check("ovf_set", 32'(ovf_o), 32'(OVF_EN));
        ovf_clr_i = 1'b1;
        @(posedge clk_i); #1;
        check("ovf_set_wins", 32'(ovf_o), 32'(OVF_EN));
        wr_valid_i = 1'b0;
        @(posedge clk_i); #1;
        ovf_clr_i = 1'b0;
        check("ovf_cleared", 32'(ovf_o), 32'd0);
        tx_hold = 1'b0;
        wait_drain("full_drain");

        // Push in the same cycle as the IDLE->LAUNCH pop.
        tx_hold = 1'b1;
        for (int i = 0; i < 5; i++) push_byte(8'(8'hA0 + i));
        check("pp_count5", 32'(count_o), 32'd5);
        tx_hold = 1'b0;
        wr_valid_i = 1'b1; wr_data_i = 8'hA5;
        sb.push_back(8'hA5);
        @(posedge clk_i); #1;
        wr_valid_i = 1'b0;
        check("pp_count_held", 32'(count_o), 32'd5);
        check("pp_launch", 32'(tx_ena_o), 32'd1);
        wait_drain("pp_drain");

        // Reset while in GUARD with seven bytes stored.
        tx_hold = 1'b1;
        for (int i = 0; i < 8; i++) push_byte(8'(8'h30 + i));
        tx_hold = 1'b0;
        begin
            int n = 0;
            while (!tx_ena_o && n < 50) begin
                @(posedge clk_i); #1;
                n++;
            end
            check("rst_mid_launch_seen", 32'(tx_ena_o), 32'd1);
        end
        @(posedge clk_i); #1;
        check("rst_mid_count7", 32'(count_o), 32'd7);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        sb.delete();
        check("rst_mid_count0", 32'(count_o), 32'd0);
        check("rst_mid_empty", 32'(empty_o), 32'd1);
        check("rst_mid_ena", 32'(tx_ena_o), 32'd0);
        repeat (30) @(posedge clk_i);
        #1;
        check("rst_mid_quiet_count", 32'(count_o), 32'd0);
        last_ena = -1;

        // Stream 40 bytes so the pointers wrap.
        for (int i = 0; i < 40; i++) push_byte(8'(i * 7 + 3));
        wait_drain("wrap_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
